// File: rtl/tx_fifo.sv
// tx_fifo: I2S transmit path. A DEPTH-entry FIFO of {L,R} sample pairs feeds
// a 64-clock stereo frame serialiser driving dout/ws (MSB first).
// Optional status outputs (full, empty, underrun) are built when the
// TXFIFO_STATUS_EN macro is defined.
module tx_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        stereo,
    input  logic [1:0]  standard,
    input  logic [1:0]  word_size,
    input  logic [31:0] dinL,
    input  logic [31:0] dinR,
    output logic        dout,
    output logic        ws
`ifdef TXFIFO_STATUS_EN
    ,
    output logic        full,
    output logic        empty,
    output logic        underrun
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [63:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [5:0]    cnt_q, cnt_d;
    logic [63:0]   frame_q, frame_d;
    logic          ph_q, ph_d;
    logic          hold_q, hold_d;
    logic          dout_q, dout_d;
    logic          ws_q, ws_d;

    logic          wr_en;
    logic          pop_tick;
    logic          pop_ok;
    logic          rj;
    logic [63:0]   pop_word;
    logic [31:0]   pop_l;
    logic [31:0]   pop_r;
    logic [5:0]    bit_idx;
    logic          raw_bit;

    // Place the W valid bits at the MSB end (Philips/LJ) or LSB end (RJ) of a 32-bit slot.
    function automatic logic [31:0] align_slot(input logic [31:0] s,
                                               input logic [1:0]  wsz,
                                               input logic        rjust);
        logic [31:0] r;
        r = '0;
        case (wsz)
            2'b00:   r = rjust ? {24'b0, s[7:0]}  : {s[7:0],  24'b0};
            2'b01:   r = rjust ? {16'b0, s[15:0]} : {s[15:0], 16'b0};
            2'b10:   r = rjust ? {8'b0,  s[23:0]} : {s[23:0], 8'b0};
            default: r = s;
        endcase
        return r;
    endfunction

    // Next-state logic for FIFO pointers, frame counter and serialiser.
    always_comb begin
        wr_en    = en && (count_q < CW'(DEPTH));
        pop_tick = en && (cnt_q == 6'd63);
        pop_ok   = pop_tick && (count_q != '0);
        rj       = (standard == 2'b10);

        wr_ptr_d = wr_en  ? AW'(wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d = pop_ok ? AW'(rd_ptr_q + AW'(1)) : rd_ptr_q;
        count_d  = CW'(count_q + CW'(wr_en) - CW'(pop_ok));
        cnt_d    = en ? 6'(cnt_q + 6'd1) : cnt_q;

        // Underrun loads zeros; mono repeats the left sample in the right slot.
        pop_word = pop_ok ? mem_q[rd_ptr_q] : '0;
        pop_l    = pop_word[63:32];
        pop_r    = stereo ? pop_word[31:0] : pop_word[63:32];

        frame_d  = frame_q;
        ph_d     = ph_q;
        if (pop_tick) begin
            frame_d = {align_slot(pop_l, word_size, rj), align_slot(pop_r, word_size, rj)};
            ph_d    = (standard == 2'b00) || (standard == 2'b11);
        end

        bit_idx  = 6'(6'd63 - cnt_q);
        raw_bit  = frame_q[bit_idx];

        hold_d   = hold_q;
        dout_d   = 1'b0;
        ws_d     = 1'b0;
        if (en) begin
            hold_d = raw_bit;
            dout_d = ph_q ? hold_q : raw_bit;
            ws_d   = cnt_q[5];
        end
    end

    // FIFO storage; write slot is chosen before any same-cycle pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_ptr_q] <= {dinL, dinR};
        end
    end

    // Control and serialiser state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            cnt_q    <= '0;
            frame_q  <= '0;
            ph_q     <= 1'b1;
            hold_q   <= 1'b0;
            dout_q   <= 1'b0;
            ws_q     <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            cnt_q    <= cnt_d;
            frame_q  <= frame_d;
            ph_q     <= ph_d;
            hold_q   <= hold_d;
            dout_q   <= dout_d;
            ws_q     <= ws_d;
        end
    end

    assign dout = dout_q;
    assign ws   = ws_q;

`ifdef TXFIFO_STATUS_EN
    logic full_q, empty_q, underrun_q;

    // Registered occupancy flags and sticky underrun.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            underrun_q <= 1'b0;
        end else begin
            full_q     <= (count_d == CW'(DEPTH));
            empty_q    <= (count_d == '0);
            underrun_q <= underrun_q || (pop_tick && (count_q == '0));
        end
    end

    assign full     = full_q;
    assign empty    = empty_q;
    assign underrun = underrun_q;
`endif

endmodule

// File: tb/tb_tx_fifo.sv
// tb_tx_fifo: scoreboard bench for tx_fifo. A behavioural model predicts
// dout/ws (and status flags when TXFIFO_STATUS_EN is defined) for every clock.
module tb_tx_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        stereo;
    logic [1:0]  standard;
    logic [1:0]  word_size;
    logic [31:0] dinL;
    logic [31:0] dinR;
    logic        dout;
    logic        ws;
`ifdef TXFIFO_STATUS_EN
    logic        full;
    logic        empty;
    logic        underrun;
`endif

    always #5 clk = ~clk;

    tx_fifo dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .stereo    (stereo),
        .standard  (standard),
        .word_size (word_size),
        .dinL      (dinL),
        .dinR      (dinR),
        .dout      (dout),
        .ws        (ws)
`ifdef TXFIFO_STATUS_EN
        ,
        .full      (full),
        .empty     (empty),
        .underrun  (underrun)
`endif
    );

    typedef struct packed {
        logic d;
        logic w;
        logic f;
        logic e;
        logic u;
    } exp_t;

    exp_t        sb_q [$];
    int          n_vec = 0;
    int          n_err = 0;

    // Reference model state
    logic [63:0] m_fifo [$];
    int          m_cnt;
    logic [31:0] m_l, m_r;
    int          m_w;
    logic        m_rj, m_ph, m_hold, m_und;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_fifo.delete();
        sb_q.delete();
        m_cnt  = 0;
        m_l    = '0;
        m_r    = '0;
        m_w    = 32;
        m_rj   = 1'b0;
        m_ph   = 1'b1;
        m_hold = 1'b0;
        m_und  = 1'b0;
    endtask

    // Bit at slot position pos (0 = first transmitted) for a W-bit sample.
    function automatic logic slot_bit(input logic [31:0] s, input int w, input logic rjust, input int pos);
        if (!rjust) return (pos < w) ? s[w-1-pos] : 1'b0;
        return (pos >= 32 - w) ? s[31-pos] : 1'b0;
    endfunction

    // Predict the outputs that follow the coming clock edge, given current inputs.
    task automatic model_step();
        exp_t        e;
        logic        raw;
        int          pre;
        logic [63:0] ent;
        e = '0;
        if (en) begin
            raw    = slot_bit((m_cnt >= 32) ? m_r : m_l, m_w, m_rj, m_cnt % 32);
            e.w    = (m_cnt >= 32);
            e.d    = m_ph ? m_hold : raw;
            m_hold = raw;
            pre    = m_fifo.size();
            if (m_cnt == 63) begin
                if (pre > 0) begin
                    ent = m_fifo.pop_front();
                end else begin
                    ent   = '0;
                    m_und = 1'b1;
                end
                m_l  = ent[63:32];
                m_r  = stereo ? ent[31:0] : ent[63:32];
                m_w  = (word_size == 2'd0) ? 8 : (word_size == 2'd1) ? 16 : (word_size == 2'd2) ? 24 : 32;
                m_rj = (standard == 2'd2);
                m_ph = (standard == 2'd0) || (standard == 2'd3);
            end
            if (pre < 8) m_fifo.push_back({dinL, dinR});
            m_cnt = (m_cnt + 1) % 64;
        end
        e.f = (m_fifo.size() == 8);
        e.e = (m_fifo.size() == 0);
        e.u = m_und;
        sb_q.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        model_step();
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("dout", 32'(dout), 32'(e.d));
        chk("ws", 32'(ws), 32'(e.w));
`ifdef TXFIFO_STATUS_EN
        chk("full", 32'(full), 32'(e.f));
        chk("empty", 32'(empty), 32'(e.e));
        chk("underrun", 32'(underrun), 32'(e.u));
`endif
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_dout"}, 32'(dout), 32'd0);
        chk({tag, "_ws"}, 32'(ws), 32'd0);
`ifdef TXFIFO_STATUS_EN
        chk({tag, "_full"}, 32'(full), 32'd0);
        chk({tag, "_empty"}, 32'(empty), 32'd1);
        chk({tag, "_underrun"}, 32'(underrun), 32'd0);
`endif
    endtask

    task automatic run_seg(input logic [1:0] std, input logic [1:0] wsz, input logic st,
                           input logic [31:0] l, input logic [31:0] r, input int frames);
        standard  = std;
        word_size = wsz;
        stereo    = st;
        dinL      = l;
        dinR      = r;
        for (int i = 0; i < frames * 64; i++) tick();
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; stereo = 1'b1; standard = 2'b00; word_size = 2'b11;
        dinL = '0; dinR = '0;
        model_reset();
        #1;
        reset_checks("rst_async");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            reset_checks("rst_hold");
        end
        rst = 1'b1;

        // Fill: alternating all-ones / zeros for 10 clocks; last two must be dropped.
        en = 1'b1; stereo = 1'b1; word_size = 2'b11; standard = 2'b00;
        for (int i = 0; i < 10; i++) begin
            dinL = (i % 2 == 0) ? 32'hFFFF_FFFF : 32'h0;
            dinR = dinL;
            tick();
        end
        run_seg(2'b00, 2'b11, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 10);

        // Philips 32-bit, then LJ/RJ 16-bit, then mono.
        run_seg(2'b00, 2'b11, 1'b1, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 10);
        run_seg(2'b01, 2'b01, 1'b1, 32'h0000_ABCD, 32'h0000_1234, 10);
        run_seg(2'b10, 2'b01, 1'b1, 32'h0000_ABCD, 32'h0000_1234, 10);
        run_seg(2'b00, 2'b11, 1'b0, 32'hFFFF_FFFF, 32'h0, 10);
        run_seg(2'b11, 2'b10, 1'b1, 32'hC3C3_C3C3, 32'h3C3C_3C3C, 3);

        // Random data and config every clock, including mid-frame config changes.
        for (int i = 0; i < 6 * 64; i++) begin
            dinL      = $urandom;
            dinR      = $urandom;
            standard  = 2'($urandom_range(0, 3));
            word_size = 2'($urandom_range(0, 3));
            stereo    = 1'($urandom_range(0, 1));
            tick();
        end

        // Enable gap mid-frame: counter holds, outputs forced low.
        run_seg(2'b01, 2'b00, 1'b1, 32'h0000_0081, 32'h0000_00FE, 1);
        for (int i = 0; i < 17; i++) tick();
        en = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        en = 1'b1;
        run_seg(2'b00, 2'b00, 1'b1, 32'h0000_0055, 32'h0000_00AA, 3);

        // Asynchronous reset mid-frame, then a fresh start.
        for (int i = 0; i < 9; i++) tick();
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        reset_checks("rst_mid");
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            reset_checks("rst_mid_hold");
        end
        rst = 1'b1;
        run_seg(2'b10, 2'b11, 1'b1, 32'hDEAD_BEEF, 32'h0BAD_F00D, 10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
